// File: rtl/dircc_pmem_port2_arbiter.sv
// Two-requester arbiter for the 16-bit s2 port of the processing memory, with locked sequences and lock timeout.
// Define DIRCC_PMEM_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module dircc_pmem_port2_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [1:0]        m0_byteenable,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [1:0]        m1_byteenable,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address2,
    output logic              mem_chipselect2,
    output logic              mem_write2,
    output logic [DATA_W-1:0] mem_writedata2,
    output logic [1:0]        mem_byteenable2,
    output logic              mem_clken2,
    input  logic [DATA_W-1:0] mem_readdata2,
    output logic              lock_timeout_pulse
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? (LOCK_TIMEOUT - 1) : 0);
    localparam bit TIMEOUT_EN = (LOCK_TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic              r_rd_pend;
    logic              r_rd_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_be;
`ifdef DIRCC_PMEM_ARB_RR_EN
    logic              r_last_grant;
`endif

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_acc;
    logic w_rd_acc;
    logic w_timeout;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;
    assign w_acc  = w_gnt0 | w_gnt1;

    // Grant decision: zero-latency, at most one requester, nothing granted in reset
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 && w_req1) begin
`ifdef DIRCC_PMEM_ARB_RR_EN
                        w_gnt0 = r_last_grant;
                        w_gnt1 = ~r_last_grant;
`else
                        w_gnt0 = 1'b1;
`endif
                    end else begin
                        w_gnt0 = w_req0;
                        w_gnt1 = w_req1;
                    end
                end
                ST_LOCK0: w_gnt0 = w_req0;
                ST_LOCK1: w_gnt1 = w_req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    // Lock tracking and timeout detection
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        if (reset) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 && m0_lock) begin
                        w_state_nxt = ST_LOCK0;
                    end else if (w_gnt1 && m1_lock) begin
                        w_state_nxt = ST_LOCK1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOCK0: begin
                    if (w_gnt0 && !m0_lock) begin
                        w_state_nxt = ST_IDLE;
                    end else if (TIMEOUT_EN && (r_lock_cnt == CNT_LAST)) begin
                        w_state_nxt = ST_IDLE;
                        w_timeout   = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOCK0;
                    end
                end
                ST_LOCK1: begin
                    if (w_gnt1 && !m1_lock) begin
                        w_state_nxt = ST_IDLE;
                    end else if (TIMEOUT_EN && (r_lock_cnt == CNT_LAST)) begin
                        w_state_nxt = ST_IDLE;
                        w_timeout   = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOCK1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Memory-side drive; the buses park on the last granted values when idle
    always_comb begin
        mem_address2    = r_addr;
        mem_writedata2  = r_wdata;
        mem_byteenable2 = r_be;
        mem_write2      = 1'b0;
        w_rd_acc        = 1'b0;
        if (w_gnt0) begin
            mem_address2    = m0_address;
            mem_writedata2  = m0_writedata;
            mem_byteenable2 = m0_byteenable;
            mem_write2      = m0_write;
            w_rd_acc        = m0_read & ~m0_write;
        end else if (w_gnt1) begin
            mem_address2    = m1_address;
            mem_writedata2  = m1_writedata;
            mem_byteenable2 = m1_byteenable;
            mem_write2      = m1_write;
            w_rd_acc        = m1_read & ~m1_write;
        end else begin
            mem_write2 = 1'b0;
            w_rd_acc   = 1'b0;
        end
    end

    // State, lock counter, read-return tracking and parked bus values
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 2'b00;
`ifdef DIRCC_PMEM_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE)) begin
                r_lock_cnt <= '0;
            end else begin
                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
            r_rd_pend  <= w_rd_acc;
            r_rd_owner <= w_gnt1;
            if (w_acc) begin
                r_addr  <= mem_address2;
                r_wdata <= mem_writedata2;
                r_be    <= mem_byteenable2;
            end else begin
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
                r_be    <= r_be;
            end
`ifdef DIRCC_PMEM_ARB_RR_EN
            // A forced release counts as the lock owner's turn
            if (w_acc) begin
                r_last_grant <= w_gnt1;
            end else if (w_timeout) begin
                r_last_grant <= (r_state == ST_LOCK1);
            end else begin
                r_last_grant <= r_last_grant;
            end
`endif
        end
    end

    assign m0_waitrequest     = ~w_gnt0;
    assign m1_waitrequest     = ~w_gnt1;
    assign mem_chipselect2    = w_acc;
    assign mem_clken2         = ~reset;
    assign lock_timeout_pulse = w_timeout;
    assign m0_readdata        = mem_readdata2;
    assign m1_readdata        = mem_readdata2;
    assign m0_readdatavalid   = r_rd_pend & ~r_rd_owner & ~reset;
    assign m1_readdatavalid   = r_rd_pend &  r_rd_owner & ~reset;

endmodule

// File: tb/tb_dircc_pmem_port2_arbiter.sv
// Directed bench for dircc_pmem_port2_arbiter with a spec-level model checked every cycle plus literal checks.
module tb_dircc_pmem_port2_arbiter;

`ifdef DIRCC_PMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int LOCK_TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] m_addr [2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic [15:0] m_wd   [2];
    logic [1:0]  m_be   [2];
    logic        m_lk   [2];
    logic        m_wait [2];
    logic [15:0] m_rdata[2];
    logic        m_rdv  [2];
    logic [14:0] mem_address2;
    logic        mem_chipselect2;
    logic        mem_write2;
    logic [15:0] mem_writedata2;
    logic [1:0]  mem_byteenable2;
    logic        mem_clken2;
    logic [15:0] mem_readdata2;
    logic        lock_timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dircc_pmem_port2_arbiter #(.ADDR_W(15), .DATA_W(16), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]), .m0_writedata(m_wd[0]),
        .m0_byteenable(m_be[0]), .m0_lock(m_lk[0]), .m0_waitrequest(m_wait[0]),
        .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rdv[0]),
        .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]), .m1_writedata(m_wd[1]),
        .m1_byteenable(m_be[1]), .m1_lock(m_lk[1]), .m1_waitrequest(m_wait[1]),
        .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rdv[1]),
        .mem_address2(mem_address2), .mem_chipselect2(mem_chipselect2), .mem_write2(mem_write2),
        .mem_writedata2(mem_writedata2), .mem_byteenable2(mem_byteenable2), .mem_clken2(mem_clken2),
        .mem_readdata2(mem_readdata2), .lock_timeout_pulse(lock_timeout_pulse)
    );

    // Memory: registered address, unregistered data out, byte-enabled writes
    logic [15:0] mem_arr [0:32767];
    logic [14:0] mem_q;
    bit          mem_init = 1'b0;
    assign mem_readdata2 = mem_arr[mem_q];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32768; i++) mem_arr[i] = 16'h0000;
            mem_arr[15'h0010] = 16'hBEEF;
            mem_arr[15'h0020] = 16'h2222;
            mem_arr[15'h0100] = 16'h5A5A;
            mem_q    = 15'h0000;
            mem_init = 1'b1;
        end
        if (mem_clken2 && mem_chipselect2) begin
            if (mem_write2) begin
                if (mem_byteenable2[0]) mem_arr[mem_address2][7:0]  = mem_writedata2[7:0];
                if (mem_byteenable2[1]) mem_arr[mem_address2][15:8] = mem_writedata2[15:8];
            end
            mem_q = mem_address2;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level model: who owns the port, who is locked, which read comes back next
    int          md_lk   = -1;
    int          md_age  = 0;
    int          md_last = 1;
    bit          md_pend = 1'b0;
    int          md_pown = 0;
    logic [15:0] md_pdata;

    always @(negedge clk) begin : model
        int g;
        bit pul;
        if (reset) begin
            chk("m_rst_wait0", m_wait[0], 1);
            chk("m_rst_wait1", m_wait[1], 1);
            chk("m_rst_cs", mem_chipselect2, 0);
            chk("m_rst_wr", mem_write2, 0);
            chk("m_rst_clken", mem_clken2, 0);
            chk("m_rst_rdv0", m_rdv[0], 0);
            chk("m_rst_rdv1", m_rdv[1], 0);
            chk("m_rst_pulse", lock_timeout_pulse, 0);
            md_lk = -1; md_age = 0; md_last = 1; md_pend = 1'b0;
        end else begin
            g = -1;
            if (md_lk >= 0) begin
                if (m_rd[md_lk] || m_wr[md_lk]) g = md_lk;
            end else if ((m_rd[0] || m_wr[0]) && (m_rd[1] || m_wr[1])) begin
                g = RR ? (1 - md_last) : 0;
            end else if (m_rd[0] || m_wr[0]) begin
                g = 0;
            end else if (m_rd[1] || m_wr[1]) begin
                g = 1;
            end
            chk("m_wait0", m_wait[0], (g != 0));
            chk("m_wait1", m_wait[1], (g != 1));
            chk("m_cs", mem_chipselect2, (g >= 0));
            chk("m_clken", mem_clken2, 1);
            chk("m_wr", mem_write2, (g >= 0) ? m_wr[g] : 1'b0);
            if (g >= 0) begin
                chk("m_addr", mem_address2, m_addr[g]);
                chk("m_wdata", mem_writedata2, m_wd[g]);
                chk("m_be", mem_byteenable2, m_be[g]);
            end
            chk("m_rdv0", m_rdv[0], md_pend && (md_pown == 0));
            chk("m_rdv1", m_rdv[1], md_pend && (md_pown == 1));
            if (md_pend) chk("m_rdata", m_rdata[md_pown], md_pdata);
            pul = (md_lk >= 0) && (md_age == LOCK_TO - 1) && !((g == md_lk) && !m_lk[md_lk]);
            chk("m_pulse", lock_timeout_pulse, pul);
            if (g >= 0) begin
                md_pend  = m_rd[g] && !m_wr[g];
                md_pown  = g;
                md_pdata = mem_arr[m_addr[g]];
                md_last  = g;
            end else begin
                md_pend = 1'b0;
            end
            if (md_lk < 0) begin
                if ((g >= 0) && m_lk[g]) begin
                    md_lk  = g;
                    md_age = 0;
                end
            end else if ((g == md_lk) && !m_lk[md_lk]) begin
                md_lk = -1;
            end else if (pul) begin
                md_last = md_lk;
                md_lk   = -1;
            end else begin
                md_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req(input int n, input bit rd, input bit wr, input logic [14:0] a,
                       input logic [15:0] d, input logic [1:0] be, input bit lk);
        m_rd[n] = rd; m_wr[n] = wr; m_addr[n] = a; m_wd[n] = d; m_be[n] = be; m_lk[n] = lk;
    endtask

    task automatic idle(input int n);
        m_rd[n] = 1'b0; m_wr[n] = 1'b0; m_lk[n] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int n = 0; n < 2; n++) req(n, 1'b0, 1'b0, 15'h0000, 16'h0000, 2'b11, 1'b0);
        req(0, 1'b1, 1'b0, 15'h0010, 16'h0000, 2'b11, 1'b0);
        sample();
        chk("reset_wait0", m_wait[0], 1);
        chk("reset_clken", mem_clken2, 0);
        tick();

        // Lone read
        reset = 1'b0;
        sample();
        chk("lone_wait0", m_wait[0], 0);
        chk("lone_addr", mem_address2, 15'h0010);
        tick();
        idle(0);
        sample();
        chk("lone_rdv0", m_rdv[0], 1);
        chk("lone_rdata", m_rdata[0], 16'hBEEF);
        chk("lone_rdv1", m_rdv[1], 0);
        tick();

        // Continuous tie from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req(0, 1'b1, 1'b0, 15'h0010, 16'h0000, 2'b11, 1'b0);
        req(1, 1'b1, 1'b0, 15'h0020, 16'h0000, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("tie_wait0", m_wait[0], RR ? (i % 2) : 0);
            tick();
        end
        idle(0); idle(1);
        tick();

        // Locked read-modify-write by m1
        req(1, 1'b1, 1'b0, 15'h0100, 16'h0000, 2'b11, 1'b1);
        sample();
        chk("rmw_wait1_rd", m_wait[1], 0);
        tick();
        req(1, 1'b0, 1'b1, 15'h0100, 16'h1234, 2'b11, 1'b0);
        req(0, 1'b1, 1'b0, 15'h0100, 16'h0000, 2'b11, 1'b0);
        sample();
        chk("rmw_wait0_a", m_wait[0], 1);
        chk("rmw_wait1_wr", m_wait[1], 0);
        chk("rmw_rdata1", m_rdata[1], 16'h5A5A);
        tick();
        idle(1);
        sample();
        chk("rmw_wait0_b", m_wait[0], 0);
        tick();
        idle(0);
        sample();
        chk("rmw_rdata0", m_rdata[0], 16'h1234);
        tick();

        // Lock timeout: m0 locks then idles, m1 waits
        req(0, 1'b1, 1'b0, 15'h0010, 16'h0000, 2'b11, 1'b1);
        sample();
        chk("to_wait0", m_wait[0], 0);
        tick();
        idle(0);
        req(1, 1'b1, 1'b0, 15'h0020, 16'h0000, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("to_wait1", m_wait[1], 1);
            chk("to_pulse", lock_timeout_pulse, (i == 3));
            tick();
        end
        sample();
        chk("to_wait1_after", m_wait[1], 0);
        chk("to_pulse_after", lock_timeout_pulse, 0);
        tick();
        idle(1);
        sample();
        chk("to_rdata1", m_rdata[1], 16'h2222);
        tick();

        // Byte write then read-back by m1
        req(0, 1'b0, 1'b1, 15'h0200, 16'hAB55, 2'b10, 1'b0);
        sample();
        chk("bw_be", mem_byteenable2, 2'b10);
        chk("bw_write", mem_write2, 1);
        tick();
        idle(0);
        req(1, 1'b1, 1'b0, 15'h0200, 16'h0000, 2'b11, 1'b0);
        tick();
        idle(1);
        sample();
        chk("bw_rdv1", m_rdv[1], 1);
        chk("bw_rdata1", m_rdata[1], 16'hAB00);
        tick();

        // Simultaneous read and write: write wins
        req(0, 1'b1, 1'b1, 15'h0300, 16'h7777, 2'b11, 1'b0);
        sample();
        chk("rw_write", mem_write2, 1);
        tick();
        idle(0);
        sample();
        chk("rw_rdv0", m_rdv[0], 0);
        tick();

        // Reset while a read is pending
        req(0, 1'b1, 1'b0, 15'h0010, 16'h0000, 2'b11, 1'b0);
        tick();
        idle(0);
        reset = 1'b1;
        sample();
        chk("rr_rdv0", m_rdv[0], 0);
        chk("rr_cs", mem_chipselect2, 0);
        chk("rr_pulse", lock_timeout_pulse, 0);
        tick();
        reset = 1'b0;
        sample();
        chk("rr_rdv0_after", m_rdv[0], 0);
        tick();

        // Reset while m1 holds a lock
        req(1, 1'b1, 1'b0, 15'h0020, 16'h0000, 2'b11, 1'b1);
        tick();
        idle(1);
        req(0, 1'b1, 1'b0, 15'h0010, 16'h0000, 2'b11, 1'b0);
        sample();
        chk("rl_wait0_locked", m_wait[0], 1);
        tick();
        reset = 1'b1;
        sample();
        chk("rl_pulse", lock_timeout_pulse, 0);
        tick();
        reset = 1'b0;
        sample();
        chk("rl_wait0_free", m_wait[0], 0);
        tick();
        idle(0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dircc_pmem_port2_arbiter.md
# dircc_pmem_port2_arbiter

Shares the 16-bit second port (s2) of a node's dual-port processing memory between two bus masters: requester 0 (inbound message DMA) and requester 1 (outbound message DMA). Each requester sees a pipelined Avalon-MM slave with waitrequest and readdatavalid. The block provides round-robin arbitration, locked sequences for atomic read-modify-write, a lock timeout, and routing of fixed-latency read data. It sits between the node's message engines and the s2 port of the processing memory. The Nios core on s1 is unaffected.

## Interface
Parameters:
- ADDR_W, 15, word address width of s2 (20480 x 16-bit words)
- DATA_W, 16, data width of s2
- LOCK_TIMEOUT, 64, maximum cycles a lock may hold the grant; 0 = unlimited

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  sole clock, shared with the memory
- reset  in  1  synchronous active-high reset
- mN_address  in  ADDR_W  requester N word address (N = 0, 1)
- mN_read / mN_write  in  1  requester N read / write request
- mN_writedata  in  DATA_W  write data
- mN_byteenable  in  2  byte enables
- mN_lock  in  1  keep the grant after this transfer
- mN_waitrequest  out  1  high = transfer not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata valid
- mem_address2  out  ADDR_W  to memory s2
- mem_chipselect2, mem_write2  out  1  to memory s2
- mem_writedata2  out  DATA_W  to memory s2
- mem_byteenable2  out  2  to memory s2
- mem_clken2  out  1  memory port-2 clock enable
- mem_readdata2  in  DATA_W  memory s2 read data (unregistered output, registered address)
- lock_timeout_pulse  out  1  one-cycle pulse when a lock is force-released

## Operation
- Request: reqN = mN_read | mN_write. A transfer is accepted when reqN & ~mN_waitrequest. The requester holds all inputs stable while waitrequest is high.
- Grant is combinational from current state and requests. At most one requester is granted per cycle. A granted requester sees waitrequest = 0. All others see 1.
- States:
  - IDLE: a single requester is granted immediately. If both request, grant goes to the requester opposite `last_grant`. If an accepted transfer has mN_lock = 1, go to LOCKED_N.
  - LOCKED_N: only N may be granted; the other waits even if N is idle. Return to IDLE on an accepted N transfer with mN_lock = 0, or on timeout.
- last_grant is updated to N on every accepted N transfer.
- Timeout: lock_cnt clears on entry to LOCKED_N and increments each cycle in LOCKED_N. When it reaches LOCKED_TIMEOUT-1... more precisely, at lock_cnt == LOCK_TIMEOUT-1 with no releasing transfer, the block goes to IDLE, sets last_grant = N, and pulses lock_timeout_pulse. An accepted transfer in that same cycle completes normally.
- Memory drive on acceptance:
  - mem_chipselect2 = 1
  - mem_write2 = mN_write
  - address, data and byteenable come from the granted requester
  - Otherwise chipselect2 and write2 are 0 and the data/address buses hold the last granted values.
- Simultaneous read and write: write wins, and no readdatavalid is produced.
- byteenable = 0 writes pass through unchanged and act as a no-op.
- Read return: on an accepted read, set rd_pend = 1 and rd_owner = N. Next cycle, mN_readdatavalid = 1 and mN_readdata = mem_readdata2 for the owner. The other requester's readdatavalid stays 0. Readdata is routed directly, not registered.
- mem_clken2 = ~reset.

## Timing
- Arbitration latency is 0: a lone request is accepted in the cycle it is asserted.
- Read latency is exactly 1 cycle from acceptance to readdatavalid. One read can be accepted per cycle, back-to-back, with no bubbles.
- Write completes in the acceptance cycle.
- Reset values:
  - state = IDLE, last_grant = 1 (so requester 0 wins the first tie), lock_cnt = 0, rd_pend = 0
  - all readdatavalid = 0, mem_chipselect2 = 0, mem_write2 = 0, lock_timeout_pulse = 0
  - both waitrequest = 1, mem_clken2 = 0
- Reset mid-read drops the pending readdatavalid. Reset mid-lock returns the block to IDLE with no timeout pulse.

## Configuration
- DIRCC_PMEM_ARB_RR_EN defined: round-robin tie-break as described above.
- Not defined: fixed priority, where requester 0 always wins ties in IDLE. last_grant is unused and may be removed. Lock and timeout behaviour are unchanged.

## Test plan
- Lone read: m0 reads 0x0010 where memory holds 0xBEEF → waitrequest 0 in cycle 0; cycle 1 gives m0_readdatavalid = 1, m0_readdata = 0xBEEF, m1_readdatavalid = 0.
- Tie, round-robin: both request continuously from reset → grants alternate 0,1,0,1. With the macro undefined, requester 0 is granted every cycle.
- Locked read-modify-write: m1 reads 0x0100 with lock = 1, then writes 0x1234 with lock = 0 while m0 requests throughout → m0 waits both cycles and is granted in the third.
- Lock timeout with LOCK_TIMEOUT = 4: m0 locks and then idles while m1 requests → one lock_timeout_pulse on the 4th locked cycle; m1 is granted the next cycle.
- Byte write: m0 writes 0xAB55 with byteenable = 2'b10 to a word holding 0x0000 → m1 reads back 0xAB00.
- Reset during a pending read: assert reset in the cycle after a read is accepted → no readdatavalid; all outputs at reset values.
